// File: rtl/multicycle_controller.sv
// multicycle_controller: Moore-style sequencer for a shared multicycle datapath.
// Decodes the IR opcode class, drives datapath enables/mux selects, owns the
// carry/zero flag register and handshakes with a variable-latency data memory.
//
// state    | meaning
// ---------+----------------------------------------------------------
// S_FETCH  | load IR from instruction memory
// S_DECODE | register read, classify opcode
// S_EXEC   | ALU/shifter operation, branch/jump PC update, address calc
// S_MEM    | data memory request held until mem_ack
// S_WB     | register write-back and sequential PC update
// S_HALT   | all enables off until reset
//
// Outputs are registered from the next-state decode so each one reflects the
// state the FSM is in. The single exception is the STM acknowledge cycle, where
// pc_we must fire in the same cycle as mem_ack.
module multicycle_controller #(
  parameter int OP_W    = 6,
  parameter int ALUOP_W = 3
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [OP_W-1:0]    i_opcode,
  input  logic               i_alu_c,
  input  logic               i_alu_z,
  input  logic               i_mem_ack,
  output logic               o_ir_we,
  output logic               o_pc_we,
  output logic [1:0]         o_pc_sel,
  output logic [ALUOP_W-1:0] o_alu_op,
  output logic               o_alu_src_const,
  output logic               o_rf_rd2_sel_rd,
  output logic               o_rf_we,
  output logic [1:0]         o_rf_wsel,
  output logic               o_shift_en,
  output logic               o_mem_req,
  output logic               o_mem_we,
  output logic               o_flag_c,
  output logic               o_flag_z,
  output logic               o_halted
);

  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_t;
  typedef enum logic [2:0] {C_REG, C_IMM, C_MEM, C_BRANCH, C_SHIFT, C_JMP, C_HALT} class_t;

  state_t               r_state;
  logic                 r_ir_we, r_pc_we, r_alu_src_const, r_rf_rd2_sel_rd, r_rf_we;
  logic                 r_shift_en, r_mem_req, r_mem_we, r_halted, r_flag_c, r_flag_z;
  logic [1:0]           r_pc_sel, r_rf_wsel;
  logic [ALUOP_W-1:0]   r_alu_op;

  state_t               w_nxt;
  class_t               w_class;
  logic [1:0]           w_sub;
  logic                 w_take, w_is_stm, w_mem_nop, w_stm_ack;
  logic                 w_ir_we, w_pc_we, w_alu_src_const, w_rf_rd2_sel_rd, w_rf_we;
  logic                 w_shift_en, w_mem_req, w_mem_we, w_halted;
  logic [1:0]           w_pc_sel, w_rf_wsel;
  logic [ALUOP_W-1:0]   w_alu_op;

  // Opcode class decode in priority order, plus branch condition from the registered flags
  always_comb begin
    w_sub = i_opcode[2:1];
    if (i_opcode[OP_W-1 -: 4] == 4'b1111)      w_class = C_HALT;
    else if (i_opcode[OP_W-1 -: 4] == 4'b1110) w_class = C_JMP;
    else if (i_opcode[OP_W-1 -: 3] == 3'b110)  w_class = C_SHIFT;
    else if (i_opcode[OP_W-1 -: 3] == 3'b101)  w_class = C_BRANCH;
    else if (i_opcode[OP_W-1 -: 3] == 3'b100)  w_class = C_MEM;
    else if (i_opcode[OP_W-1 -: 2] == 2'b01)   w_class = C_IMM;
    else                                       w_class = C_REG;
    case (w_sub)
      2'b00:   w_take = r_flag_z;
      2'b01:   w_take = ~r_flag_z;
      2'b10:   w_take = r_flag_c;
      default: w_take = ~r_flag_c;
    endcase
    w_is_stm  = (w_sub == 2'b01);
    w_mem_nop = w_sub[1];
    w_stm_ack = (r_state == S_MEM) && (w_class == C_MEM) && w_is_stm && i_mem_ack;
  end

  // Next-state selection and the output values that state will present
  always_comb begin
    w_nxt = S_FETCH;
    case (r_state)
      S_FETCH:  w_nxt = S_DECODE;
      S_DECODE: w_nxt = (w_class == C_HALT) ? S_HALT : S_EXEC;
      S_EXEC: begin
        if (w_class == C_BRANCH || w_class == C_JMP) w_nxt = S_FETCH;
        else if (w_class == C_MEM && !w_mem_nop)     w_nxt = S_MEM;
        else                                         w_nxt = S_WB;
      end
      S_MEM:    w_nxt = !i_mem_ack ? S_MEM : (w_is_stm ? S_FETCH : S_WB);
      S_WB:     w_nxt = S_FETCH;
      S_HALT:   w_nxt = S_HALT;
      default:  w_nxt = S_FETCH;
    endcase

    w_ir_we = 1'b0; w_pc_we = 1'b0; w_pc_sel = 2'b00; w_alu_op = '0;
    w_alu_src_const = 1'b0; w_rf_rd2_sel_rd = 1'b0; w_rf_we = 1'b0; w_rf_wsel = 2'b00;
    w_shift_en = 1'b0; w_mem_req = 1'b0; w_mem_we = 1'b0; w_halted = 1'b0;
    case (w_nxt)
      S_FETCH: w_ir_we = 1'b1;
      S_EXEC: begin
        case (w_class)
          C_REG:    w_alu_op = i_opcode[ALUOP_W-1:0];
          C_IMM: begin
            w_alu_op        = i_opcode[ALUOP_W-1:0];
            w_alu_src_const = 1'b1;
          end
          C_SHIFT:  w_shift_en = 1'b1;
          C_MEM:    w_alu_src_const = 1'b1;
          C_BRANCH: begin
            w_pc_we  = 1'b1;
            w_pc_sel = w_take ? 2'b01 : 2'b00;
          end
          C_JMP: begin
            w_pc_we  = 1'b1;
            w_pc_sel = 2'b10;
          end
          default: ;
        endcase
      end
      S_MEM: begin
        w_mem_req       = 1'b1;
        w_mem_we        = w_is_stm;
        w_rf_rd2_sel_rd = w_is_stm;
      end
      S_WB: begin
        w_pc_we = 1'b1;
        w_rf_we = !(w_class == C_MEM && w_mem_nop);
        if (w_class == C_SHIFT)    w_rf_wsel = 2'b10;
        else if (w_class == C_MEM) w_rf_wsel = 2'b01;
      end
      S_HALT: w_halted = 1'b1;
      default: ;
    endcase
  end

  // State, registered outputs and flag capture on the edge leaving EXEC
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_FETCH;
      r_ir_we <= 1'b1; r_pc_we <= 1'b0; r_pc_sel <= 2'b00; r_alu_op <= '0;
      r_alu_src_const <= 1'b0; r_rf_rd2_sel_rd <= 1'b0; r_rf_we <= 1'b0; r_rf_wsel <= 2'b00;
      r_shift_en <= 1'b0; r_mem_req <= 1'b0; r_mem_we <= 1'b0; r_halted <= 1'b0;
      r_flag_c <= 1'b0; r_flag_z <= 1'b0;
    end else begin
      r_state <= w_nxt;
      r_ir_we <= w_ir_we; r_pc_we <= w_pc_we; r_pc_sel <= w_pc_sel; r_alu_op <= w_alu_op;
      r_alu_src_const <= w_alu_src_const; r_rf_rd2_sel_rd <= w_rf_rd2_sel_rd;
      r_rf_we <= w_rf_we; r_rf_wsel <= w_rf_wsel; r_shift_en <= w_shift_en;
      r_mem_req <= w_mem_req; r_mem_we <= w_mem_we; r_halted <= w_halted;
      if (r_state == S_EXEC && (w_class == C_REG || w_class == C_IMM || w_class == C_SHIFT)) begin
        r_flag_c <= i_alu_c;
        r_flag_z <= i_alu_z;
      end
    end
  end

  assign o_ir_we         = r_ir_we;
  assign o_pc_we         = r_pc_we | w_stm_ack;
  assign o_pc_sel        = r_pc_sel;
  assign o_alu_op        = r_alu_op;
  assign o_alu_src_const = r_alu_src_const;
  assign o_rf_rd2_sel_rd = r_rf_rd2_sel_rd;
  assign o_rf_we         = r_rf_we;
  assign o_rf_wsel       = r_rf_wsel;
  assign o_shift_en      = r_shift_en;
  assign o_mem_req       = r_mem_req;
  assign o_mem_we        = r_mem_we;
  assign o_flag_c        = r_flag_c;
  assign o_flag_z        = r_flag_z;
  assign o_halted        = r_halted;

endmodule
